// File: rtl/elevator_ctrl_if.sv
// Request/status bundle between the per-floor request latches and the car controller.
// The controller drives the master side; the latch bank and observers sit on the slave side.
interface elevator_ctrl_if #(
    parameter int NUM_FLOORS = 3
);
    localparam int FW = $clog2(NUM_FLOORS);

    logic [NUM_FLOORS-1:0] req;
    logic [NUM_FLOORS-1:0] done;
    logic [FW-1:0]         cur_floor;
    logic                  moving_up;
    logic                  moving_down;
    logic                  door_open;

    modport master (
        input  req,
        output done, cur_floor, moving_up, moving_down, door_open
    );

    modport slave (
        output req,
        input  done, cur_floor, moving_up, moving_down, door_open
    );
endinterface

// File: rtl/elevator_ctrl.sv
// SCAN elevator car controller: moves one floor per MOVE_CYCLES, opens the door at
// requested floors and returns a one-cycle done pulse to clear the matching request latch.
module elevator_ctrl #(
    parameter int NUM_FLOORS  = 3,
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic            Clock,
    input  logic            Reset,
    elevator_ctrl_if.master bus
);
    localparam int FW   = $clog2(NUM_FLOORS);
    localparam int MAXC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;
    typedef enum logic       {DIR_UP, DIR_DOWN}              dir_t;

    state_t        state;
    dir_t          dir;
    logic [TW-1:0] timer;

    // Request summaries relative to the current floor and to the floor about to be reached.
    logic above, below, here;
    logic here_up, ahead_up, here_dn, ahead_dn;
    int   cur_i;

    function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FW-1:0] f);
        logic [NUM_FLOORS-1:0] onehot;
        onehot = '0;
        for (int j = 0; j < NUM_FLOORS; j++) begin
            if (int'(f) == j) onehot[j] = 1'b1;
        end
        return onehot;
    endfunction

    // NOTE: every always_comb output gets a default before any condition, so no latch is inferred.
    always_comb begin
        cur_i    = int'(bus.cur_floor);
        above    = 1'b0;
        below    = 1'b0;
        here     = 1'b0;
        here_up  = 1'b0;
        ahead_up = 1'b0;
        here_dn  = 1'b0;
        ahead_dn = 1'b0;
        for (int j = 0; j < NUM_FLOORS; j++) begin
            if (j >  cur_i)     above    = above    | bus.req[j];
            if (j <  cur_i)     below    = below    | bus.req[j];
            if (j == cur_i)     here     = bus.req[j];
            if (j == cur_i + 1) here_up  = bus.req[j];
            if (j >  cur_i + 1) ahead_up = ahead_up | bus.req[j];
            if (j == cur_i - 1) here_dn  = bus.req[j];
            if (j <  cur_i - 1) ahead_dn = ahead_dn | bus.req[j];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state           <= IDLE;
            dir             <= DIR_UP;
            timer           <= '0;
            bus.cur_floor   <= '0;
            bus.done        <= '0;
            bus.moving_up   <= 1'b0;
            bus.moving_down <= 1'b0;
            bus.door_open   <= 1'b0;
        end else begin
            bus.done <= '0;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (here) begin
                        state         <= DOOR;
                        bus.door_open <= 1'b1;
                        if (DOOR_LAST == '0) bus.done <= floor_bit(bus.cur_floor);
                    end else if (dir == DIR_UP && above) begin
                        state         <= MOVE_UP;
                        bus.moving_up <= 1'b1;
                    end else if (dir == DIR_DOWN && below) begin
                        state           <= MOVE_DOWN;
                        bus.moving_down <= 1'b1;
                    end else if (above) begin
                        state         <= MOVE_UP;
                        dir           <= DIR_UP;
                        bus.moving_up <= 1'b1;
                    end else if (below) begin
                        state           <= MOVE_DOWN;
                        dir             <= DIR_DOWN;
                        bus.moving_down <= 1'b1;
                    end
                end

                MOVE_UP: begin
                    if (timer == MOVE_LAST) begin
                        timer         <= '0;
                        bus.cur_floor <= bus.cur_floor + FW'(1);
                        if (here_up) begin
                            state         <= DOOR;
                            bus.moving_up <= 1'b0;
                            bus.door_open <= 1'b1;
                            if (DOOR_LAST == '0) bus.done <= floor_bit(bus.cur_floor + FW'(1));
                        end else if (!ahead_up) begin
                            // Requests withdrawn mid-trip: park and re-evaluate.
                            state         <= IDLE;
                            bus.moving_up <= 1'b0;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                MOVE_DOWN: begin
                    if (timer == MOVE_LAST) begin
                        timer         <= '0;
                        bus.cur_floor <= bus.cur_floor - FW'(1);
                        if (here_dn) begin
                            state           <= DOOR;
                            bus.moving_down <= 1'b0;
                            bus.door_open   <= 1'b1;
                            if (DOOR_LAST == '0) bus.done <= floor_bit(bus.cur_floor - FW'(1));
                        end else if (!ahead_dn) begin
                            state           <= IDLE;
                            bus.moving_down <= 1'b0;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                DOOR: begin
                    if (timer == DOOR_LAST) begin
                        state         <= IDLE;
                        timer         <= '0;
                        bus.door_open <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                        // done is registered, so it is raised on the edge entering the final door cycle.
                        if (timer + TW'(1) == DOOR_LAST) bus.done <= floor_bit(bus.cur_floor);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: directed scenarios then random requests, all compared each
// cycle against a countdown-based reference model of the car plus a request-latch model.
module tb_elevator_ctrl;
    localparam int NF    = 3;
    localparam int MOVE  = 4;
    localparam int DOORC = 3;

    logic Clock;
    logic Reset;

    elevator_ctrl_if #(.NUM_FLOORS(NF)) bus ();

    elevator_ctrl #(
        .NUM_FLOORS (NF),
        .MOVE_CYCLES(MOVE),
        .DOOR_CYCLES(DOORC)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    int total;
    int bad;
    int done_seen;

    // Reference model: floor index, preferred direction (+1/-1), motion (+1/-1/0)
    // and remaining cycles of the current move or door opening.
    int m_floor, m_dir, m_motion, m_move_left, m_door_left;
    logic [NF-1:0] latch;

    function automatic logic [NF-1:0] fbit(input int f);
        logic [NF-1:0] r;
        r    = '0;
        r[f] = 1'b1;
        return r;
    endfunction

    function automatic bit pending_toward(input logic [NF-1:0] r, input int from, input int d);
        for (int f = 0; f < NF; f++) begin
            if ((f - from) * d > 0 && r[f]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [NF-1:0] exp_done();
        return (m_door_left == 1) ? fbit(m_floor) : '0;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_dir = 1; m_motion = 0; m_move_left = 0; m_door_left = 0;
    endtask

    task automatic model_step(input logic [NF-1:0] r);
        if (m_door_left > 0) begin
            m_door_left--;
        end else if (m_motion != 0) begin
            m_move_left--;
            if (m_move_left == 0) begin
                m_floor += m_motion;
                if (r[m_floor]) begin
                    m_motion    = 0;
                    m_door_left = DOORC;
                end else if (pending_toward(r, m_floor, m_motion)) begin
                    m_move_left = MOVE;
                end else begin
                    m_motion = 0;
                end
            end
        end else if (r[m_floor]) begin
            m_door_left = DOORC;
        end else if (pending_toward(r, m_floor, m_dir)) begin
            m_motion = m_dir; m_move_left = MOVE;
        end else if (pending_toward(r, m_floor, -m_dir)) begin
            m_dir = -m_dir; m_motion = m_dir; m_move_left = MOVE;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".cur_floor"},   32'(bus.cur_floor),   32'(m_floor));
        check({tag, ".moving_up"},   32'(bus.moving_up),   32'(m_motion > 0));
        check({tag, ".moving_down"}, 32'(bus.moving_down), 32'(m_motion < 0));
        check({tag, ".door_open"},   32'(bus.door_open),   32'(m_door_left > 0));
        check({tag, ".done"},        32'(bus.done),        32'(exp_done()));
    endtask

    // One clock: raise new requests into the latches, let the DUT and model take the
    // edge, clear latches hit by the done pulse of the cycle just ended, then compare.
    task automatic tick(input string tag, input logic [NF-1:0] set_bits);
        logic [NF-1:0] snap, prev_done;
        latch     = latch | set_bits;
        bus.req   = latch;
        snap      = latch;
        prev_done = exp_done();
        @(posedge Clock);
        model_step(snap);
        latch = latch & ~prev_done;
        #1 bus.req = latch;
        @(negedge Clock);
        if (bus.done != '0) done_seen++;
        check_all(tag);
    endtask

    initial begin
        total = 0; bad = 0; done_seen = 0;
        latch = '0;
        bus.req = '0;
        Reset = 1'b0;
        model_reset();

        #3 check_all("reset");
        @(negedge Clock);
        #2 Reset = 1'b1;

        // Request at the current floor: door opens without moving.
        tick("here", 3'b001);
        repeat (4) tick("here", '0);

        // Basic trip to floor 1.
        tick("trip", 3'b010);
        check("trip.first_move_up", 32'(bus.moving_up), 32'd1);
        repeat (8) tick("trip", '0);
        check("trip.arrived_floor", 32'(bus.cur_floor), 32'd1);

        // SCAN from floor 1 heading up with requests on both sides.
        tick("scan", 3'b101);
        repeat (26) tick("scan", '0);
        check("scan.end_floor", 32'(bus.cur_floor), 32'd0);

        // Pass-by stop: floor 1 requested two cycles into a 0->2 trip.
        tick("passby", 3'b100);
        tick("passby", '0);
        tick("passby", 3'b010);
        repeat (24) tick("passby", '0);
        check("passby.end_floor", 32'(bus.cur_floor), 32'd2);

        // Door absorb: the current floor is requested again while the door is open.
        done_seen = 0;
        tick("absorb", 3'b100);
        tick("absorb", '0);
        tick("absorb", 3'b100);
        repeat (5) tick("absorb", '0);
        check("absorb.done_pulses", 32'(done_seen), 32'd1);
        check("absorb.door_closed", 32'(bus.door_open), 32'd0);

        // Async reset in the middle of a downward move, between clock edges.
        tick("rst", 3'b001);
        tick("rst", '0);
        tick("rst", '0);
        check("rst.moving_down_before", 32'(bus.moving_down), 32'd1);
        #2 Reset = 1'b0;
        model_reset();
        #1 check_all("rst.async");
        @(negedge Clock);
        #2 Reset = 1'b1;
        done_seen = 0;
        repeat (6) tick("rst.after", '0);
        check("rst.pending_served", 32'(done_seen), 32'd1);

        // Random request arrivals.
        for (int i = 0; i < 2000; i++) begin
            logic [NF-1:0] s;
            s = '0;
            if ($urandom_range(0, 5) == 0) s = fbit(int'($urandom_range(0, NF - 1)));
            tick("rand", s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
